mem_access_unit: RTL and testbench

MEM-stage load/store unit of the CPU. It sits directly upstream of the data RAM and downstream of the execute stage.
- Accepts one memory request at a time through a valid/ready handshake.
- Checks address alignment and drives the RAM port: enable, write enable, 4-bit big-endian byte select, word address and lane-replicated store data.
- Formats load data with sign or zero extension.
- Returns a registered response (result, destination register, exception flag) to writeback.

---
 rtl/mem_access_unit_pkg.sv | 49 ++++
 rtl/mem_access_unit_lane_align.sv | 58 +++++
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit:
// op codes, lane-select constants and enable levels.
package mem_access_unit_pkg;

   localparam int MEM_OP_W = 4;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_LB  = 4'd1,
      OP_LBU = 4'd2,
      OP_LH  = 4'd3,
      OP_LHU = 4'd4,
      OP_LW  = 4'd5,
      OP_SB  = 4'd6,
      OP_SH  = 4'd7,
      OP_SW  = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } mau_state_e;

   // bit3 of a select is data[31:24], i.e. byte offset 0
   localparam logic [3:0] SEL_NONE  = 4'b0000;
   localparam logic [3:0] SEL_BYTE0 = 4'b1000;
   localparam logic [3:0] SEL_HALF0 = 4'b1100;
   localparam logic [3:0] SEL_HALF2 = 4'b0011;
   localparam logic [3:0] SEL_WORD  = 4'b1111;

   localparam logic WRITE_ENABLE = 1'b1;
   localparam logic CHIP_ENABLE  = 1'b1;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   function automatic logic is_store(mem_op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic misaligned(mem_op_e op, logic [1:0] k);
      logic half;
      logic word;
      half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      word = (op == OP_LW) || (op == OP_SW);
      return (half && k[0]) || (word && (k != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store select/replication and load
// extraction with sign or zero extension.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  mem_op_e     op_i,
   input  logic [1:0]  k_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  sel_o,
   output logic [31:0] st_data_o,
   output logic [31:0] ld_data_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   // pick the addressed byte / half from the big-endian word
   always_comb begin
      byte_w = rdata_i[31 - 8*k_i -: 8];
      half_w = k_i[1] ? rdata_i[15:0] : rdata_i[31:16];
   end

   // store lane select and replicated data
   always_comb begin
      sel_o     = SEL_NONE;
      st_data_o = ZERO_WORD;
      unique case (op_i)
         OP_SB: begin
            sel_o     = SEL_BYTE0 >> k_i;
            st_data_o = {4{wdata_i[7:0]}};
         end
         OP_SH: begin
            sel_o     = k_i[1] ? SEL_HALF2 : SEL_HALF0;
            st_data_o = {2{wdata_i[15:0]}};
         end
         OP_SW: begin
            sel_o     = SEL_WORD;
            st_data_o = wdata_i;
         end
         default: ;
      endcase
   end

   // load formatting
   always_comb begin
      ld_data_o = ZERO_WORD;
      unique case (op_i)
         OP_LB:   ld_data_o = {{24{byte_w[7]}}, byte_w};
         OP_LBU:  ld_data_o = {24'h0, byte_w};
         OP_LH:   ld_data_o = {{16{half_w[15]}}, half_w};
         OP_LHU:  ld_data_o = {16'h0, half_w};
         OP_LW:   ld_data_o = rdata_i;
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one request at a time, alignment
// check, RAM port sequencing and a registered response.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int WAIT_CYCLES = 0,
   parameter int OP_W        = MEM_OP_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [OP_W-1:0] req_op,
   input  logic [31:0]     req_addr,
   input  logic [31:0]     req_wdata,
   input  logic [4:0]      req_rd,
   input  logic            req_wb_en,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [31:0]     resp_data,
   output logic [4:0]      resp_rd,
   output logic            resp_wb_en,
   output logic            resp_exc,
   output logic [31:0]     resp_bad_addr,
   output logic            ram_en,
   output logic            ram_write_en,
   output logic [3:0]      ram_write_sel,
   output logic [31:0]     ram_addr,
   output logic [31:0]     ram_write_data,
   input  logic [31:0]     ram_read_data
);

   mau_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   mem_op_e     op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic        wb_q, wb_d;
   logic        exc_q, exc_d;
   logic [31:0] rdat_q, rdat_d;

   mem_op_e     new_op;
   logic        commit;
   logic [3:0]  sel_w;
   logic [31:0] st_w;
   logic [31:0] ld_w;
   logic        in_resp;

   mem_lane_align u_align (
      .op_i      (op_q),
      .k_i       (addr_q[1:0]),
      .wdata_i   (wdata_q),
      .rdata_i   (ram_read_data),
      .sel_o     (sel_w),
      .st_data_o (st_w),
      .ld_data_o (ld_w)
   );

   // unknown op codes collapse to NOP
   always_comb begin
      new_op = OP_NOP;
      if (req_op <= OP_W'(OP_SW)) begin
         new_op = mem_op_e'(req_op[3:0]);
      end
   end

   // next-state, request latching and response capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wb_d    = wb_q;
      exc_d   = exc_q;
      rdat_d  = rdat_q;
      commit  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && !flush) begin
               op_d    = new_op;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rd_d    = req_rd;
               wb_d    = req_wb_en;
               exc_d   = misaligned(new_op, req_addr[1:0]);
               if (exc_d) begin
                  rdat_d  = ZERO_WORD;
                  state_d = ST_RESP;
               end else if (new_op == OP_NOP) begin
                  rdat_d  = req_wdata;
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = 4'(WAIT_CYCLES);
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               commit  = is_store(op_q);
               rdat_d  = is_store(op_q) ? ZERO_WORD : ld_w;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end
   end

   // state and latched request registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         op_q    <= OP_NOP;
         addr_q  <= ZERO_WORD;
         wdata_q <= ZERO_WORD;
         rd_q    <= 5'd0;
         wb_q    <= 1'b0;
         exc_q   <= 1'b0;
         rdat_q  <= ZERO_WORD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wb_q    <= wb_d;
         exc_q   <= exc_d;
         rdat_q  <= rdat_d;
      end
   end

   // RAM port and response outputs, zero outside their state
   always_comb begin
      in_resp        = (state_q == ST_RESP);
      req_ready      = rst && (state_q == ST_IDLE);
      ram_en         = (state_q == ST_ACCESS) ? CHIP_ENABLE : ~CHIP_ENABLE;
      ram_write_en   = (commit && !flush) ? WRITE_ENABLE : ~WRITE_ENABLE;
      ram_write_sel  = ram_en ? sel_w : SEL_NONE;
      ram_write_data = ram_en ? st_w : ZERO_WORD;
      ram_addr       = ram_en ? {addr_q[31:2], 2'b00} : ZERO_WORD;
      resp_valid     = in_resp;
      resp_data      = in_resp ? rdat_q : ZERO_WORD;
      resp_rd        = in_resp ? rd_q : 5'd0;
      resp_exc       = in_resp && exc_q;
      resp_wb_en     = in_resp && wb_q && !exc_q && !is_store(op_q);
      resp_bad_addr  = (in_resp && exc_q) ? addr_q : ZERO_WORD;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit: one instance
// with WAIT_CYCLES=0 and one with WAIT_CYCLES=3.
module tb_mem_access_unit;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wb;
      logic        exc;
      logic [31:0] bad;
   } exp_t;

   localparam logic [3:0] O_NOP = 4'd0;
   localparam logic [3:0] O_LB  = 4'd1;
   localparam logic [3:0] O_LBU = 4'd2;
   localparam logic [3:0] O_LH  = 4'd3;
   localparam logic [3:0] O_LHU = 4'd4;
   localparam logic [3:0] O_LW  = 4'd5;
   localparam logic [3:0] O_SB  = 4'd6;
   localparam logic [3:0] O_SH  = 4'd7;
   localparam logic [3:0] O_SW  = 4'd8;

   logic clk = 1'b0;
   logic rst;

   logic        flush[2];
   logic        req_valid[2];
   logic        req_ready[2];
   logic [3:0]  req_op[2];
   logic [31:0] req_addr[2];
   logic [31:0] req_wdata[2];
   logic [4:0]  req_rd[2];
   logic        req_wb_en[2];
   logic        resp_valid[2];
   logic        resp_ready[2];
   logic [31:0] resp_data[2];
   logic [4:0]  resp_rd[2];
   logic        resp_wb_en[2];
   logic        resp_exc[2];
   logic [31:0] resp_bad_addr[2];
   logic        ram_en[2];
   logic        ram_write_en[2];
   logic [3:0]  ram_write_sel[2];
   logic [31:0] ram_addr[2];
   logic [31:0] ram_write_data[2];
   logic [31:0] ram_read_data[2];

   logic [31:0] mem[2][64];
   int          en_cnt[2];
   int          we_cnt[2];
   logic [3:0]  last_sel[2];
   logic [31:0] last_wd[2];
   logic [31:0] last_wa[2];

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      mem_access_unit #(
         .WAIT_CYCLES ((g == 0) ? 0 : 3),
         .OP_W        (4)
      ) u_dut (
         .clk            (clk),
         .rst            (rst),
         .flush          (flush[g]),
         .req_valid      (req_valid[g]),
         .req_ready      (req_ready[g]),
         .req_op         (req_op[g]),
         .req_addr       (req_addr[g]),
         .req_wdata      (req_wdata[g]),
         .req_rd         (req_rd[g]),
         .req_wb_en      (req_wb_en[g]),
         .resp_valid     (resp_valid[g]),
         .resp_ready     (resp_ready[g]),
         .resp_data      (resp_data[g]),
         .resp_rd        (resp_rd[g]),
         .resp_wb_en     (resp_wb_en[g]),
         .resp_exc       (resp_exc[g]),
         .resp_bad_addr  (resp_bad_addr[g]),
         .ram_en         (ram_en[g]),
         .ram_write_en   (ram_write_en[g]),
         .ram_write_sel  (ram_write_sel[g]),
         .ram_addr       (ram_addr[g]),
         .ram_write_data (ram_write_data[g]),
         .ram_read_data  (ram_read_data[g])
      );
   end

   // combinational RAM read, one RAM per instance
   always_comb begin
      for (int g = 0; g < 2; g++) begin
         ram_read_data[g] = mem[g][ram_addr[g][7:2]];
      end
   end

   // RAM write model and activity monitors
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (ram_en[g]) en_cnt[g] <= en_cnt[g] + 1;
         if (ram_write_en[g]) begin
            we_cnt[g]   <= we_cnt[g] + 1;
            last_sel[g] <= ram_write_sel[g];
            last_wd[g]  <= ram_write_data[g];
            last_wa[g]  <= ram_addr[g];
            for (int b = 0; b < 4; b++) begin
               if (ram_write_sel[g][3-b]) begin
                  mem[g][ram_addr[g][7:2]][31-8*b -: 8] <=
                     ram_write_data[g][31-8*b -: 8];
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [4:0] rd,
                       input logic wb, input logic exc,
                       input logic [31:0] bad);
      exp_t e;
      e.data = d;
      e.rd   = rd;
      e.wb   = wb;
      e.exc  = exc;
      e.bad  = bad;
      sbq.push_back(e);
   endtask

   task automatic send(input int g, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic wb);
      @(negedge clk);
      chk("req_ready_before", {31'd0, req_ready[g]}, 32'd1);
      req_op[g]    = op;
      req_addr[g]  = a;
      req_wdata[g] = d;
      req_rd[g]    = rd;
      req_wb_en[g] = wb;
      req_valid[g] = 1'b1;
      @(negedge clk);
      req_valid[g] = 1'b0;
   endtask

   task automatic get_resp(input int g, input int lat, input int hold,
                           input string tag);
      int   w;
      exp_t e;
      w = 0;
      while (resp_valid[g] !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "/latency"}, 32'(w), 32'(lat));
      if (sbq.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s/scoreboard: observed empty expected entry", tag);
         return;
      end
      e = sbq.pop_front();
      for (int h = 0; h <= hold; h++) begin
         chk({tag, "/valid"}, {31'd0, resp_valid[g]}, 32'd1);
         chk({tag, "/data"}, resp_data[g], e.data);
         chk({tag, "/rd"}, {27'd0, resp_rd[g]}, {27'd0, e.rd});
         chk({tag, "/wb_en"}, {31'd0, resp_wb_en[g]}, {31'd0, e.wb});
         chk({tag, "/exc"}, {31'd0, resp_exc[g]}, {31'd0, e.exc});
         chk({tag, "/bad_addr"}, resp_bad_addr[g], e.bad);
         chk({tag, "/ready_busy"}, {31'd0, req_ready[g]}, 32'd0);
         if (h < hold) @(negedge clk);
      end
      resp_ready[g] = 1'b1;
      @(negedge clk);
      resp_ready[g] = 1'b0;
      chk({tag, "/valid_drop"}, {31'd0, resp_valid[g]}, 32'd0);
      chk({tag, "/ready_back"}, {31'd0, req_ready[g]}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int w0;
      rst = 1'b0;
      for (int g = 0; g < 2; g++) begin
         flush[g]      = 1'b0;
         req_valid[g]  = 1'b0;
         req_op[g]     = 4'd0;
         req_addr[g]   = 32'd0;
         req_wdata[g]  = 32'd0;
         req_rd[g]     = 5'd0;
         req_wb_en[g]  = 1'b0;
         resp_ready[g] = 1'b0;
      end
      #2;
      chk("rst/req_ready", {31'd0, req_ready[0]}, 32'd0);
      chk("rst/resp_valid", {31'd0, resp_valid[1]}, 32'd0);
      chk("rst/ram_en", {31'd0, ram_en[0]}, 32'd0);
      chk("rst/ram_addr", ram_addr[0], 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // SW 0x10 on the zero-wait instance
      e0 = en_cnt[0];
      w0 = we_cnt[0];
      push(32'd0, 5'd1, 1'b0, 1'b0, 32'd0);
      send(0, O_SW, 32'h10, 32'hDEADBEEF, 5'd1, 1'b1);
      get_resp(0, 1, 0, "sw0");
      chk("sw0/en_cycles", 32'(en_cnt[0] - e0), 32'd1);
      chk("sw0/we_cycles", 32'(we_cnt[0] - w0), 32'd1);
      chk("sw0/sel", {28'd0, last_sel[0]}, 32'hF);
      chk("sw0/wdata", last_wd[0], 32'hDEADBEEF);
      chk("sw0/waddr", last_wa[0], 32'h10);

      push(32'hDEADBEEF, 5'd3, 1'b1, 1'b0, 32'd0);
      send(0, O_LW, 32'h10, 32'd0, 5'd3, 1'b1);
      get_resp(0, 1, 0, "lw0");

      // byte/half lanes on word 0x80FF7F01
      push(32'd0, 5'd2, 1'b0, 1'b0, 32'd0);
      send(0, O_SW, 32'h10, 32'h80FF7F01, 5'd2, 1'b1);
      get_resp(0, 1, 0, "sw1");
      push(32'hFFFFFFFF, 5'd4, 1'b1, 1'b0, 32'd0);
      send(0, O_LB, 32'h11, 32'd0, 5'd4, 1'b1);
      get_resp(0, 1, 0, "lb");
      push(32'h000000FF, 5'd5, 1'b1, 1'b0, 32'd0);
      send(0, O_LBU, 32'h11, 32'd0, 5'd5, 1'b1);
      get_resp(0, 1, 0, "lbu");
      push(32'h00007F01, 5'd6, 1'b1, 1'b0, 32'd0);
      send(0, O_LH, 32'h12, 32'd0, 5'd6, 1'b1);
      get_resp(0, 1, 0, "lh2");

      w0 = we_cnt[0];
      push(32'd0, 5'd8, 1'b0, 1'b0, 32'd0);
      send(0, O_SB, 32'h13, 32'h000000AA, 5'd8, 1'b1);
      get_resp(0, 1, 0, "sb3");
      chk("sb3/we_cycles", 32'(we_cnt[0] - w0), 32'd1);
      chk("sb3/sel", {28'd0, last_sel[0]}, 32'h1);
      chk("sb3/wdata", last_wd[0], 32'hAAAAAAAA);
      push(32'h80FF7FAA, 5'd9, 1'b1, 1'b0, 32'd0);
      send(0, O_LW, 32'h10, 32'd0, 5'd9, 1'b1);
      get_resp(0, 1, 0, "lw_after_sb");
      push(32'hFFFF80FF, 5'd10, 1'b1, 1'b0, 32'd0);
      send(0, O_LH, 32'h10, 32'd0, 5'd10, 1'b1);
      get_resp(0, 1, 0, "lh0");
      push(32'h000080FF, 5'd11, 1'b1, 1'b0, 32'd0);
      send(0, O_LHU, 32'h10, 32'd0, 5'd11, 1'b1);
      get_resp(0, 1, 0, "lhu0");

      // misaligned accesses never touch the RAM
      e0 = en_cnt[0];
      w0 = we_cnt[0];
      push(32'd0, 5'd12, 1'b0, 1'b1, 32'h22);
      send(0, O_LW, 32'h22, 32'd0, 5'd12, 1'b1);
      get_resp(0, 0, 0, "lw_mis");
      push(32'd0, 5'd13, 1'b0, 1'b1, 32'h21);
      send(0, O_SH, 32'h21, 32'h5555, 5'd13, 1'b1);
      get_resp(0, 0, 0, "sh_mis");
      chk("mis/en_cycles", 32'(en_cnt[0] - e0), 32'd0);
      chk("mis/we_cycles", 32'(we_cnt[0] - w0), 32'd0);

      // NOP pass-through and an unknown code handled as NOP
      e0 = en_cnt[0];
      push(32'h12345678, 5'd7, 1'b1, 1'b0, 32'd0);
      send(0, O_NOP, 32'h13, 32'h12345678, 5'd7, 1'b1);
      get_resp(0, 0, 0, "nop");
      push(32'hCAFEF00D, 5'd14, 1'b0, 1'b0, 32'd0);
      send(0, 4'hF, 32'h40, 32'hCAFEF00D, 5'd14, 1'b0);
      get_resp(0, 0, 0, "op_unknown");
      chk("nop/en_cycles", 32'(en_cnt[0] - e0), 32'd0);

      // three-wait instance: latency and held response
      push(32'd0, 5'd1, 1'b0, 1'b0, 32'd0);
      send(1, O_SW, 32'h40, 32'h11223344, 5'd1, 1'b1);
      get_resp(1, 4, 0, "sw_w3");
      e0 = en_cnt[1];
      push(32'h11223344, 5'd2, 1'b1, 1'b0, 32'd0);
      send(1, O_LW, 32'h40, 32'd0, 5'd2, 1'b1);
      get_resp(1, 4, 4, "lw_w3");
      chk("lw_w3/en_cycles", 32'(en_cnt[1] - e0), 32'd4);

      // flush during the final ACCESS cycle of a store
      w0 = we_cnt[1];
      send(1, O_SW, 32'h40, 32'h99999999, 5'd3, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      flush[1] = 1'b1;
      #1;
      chk("flush/ram_en", {31'd0, ram_en[1]}, 32'd1);
      chk("flush/write_en", {31'd0, ram_write_en[1]}, 32'd0);
      @(posedge clk);
      #1;
      flush[1] = 1'b0;
      chk("flush/req_ready", {31'd0, req_ready[1]}, 32'd1);
      chk("flush/resp_valid", {31'd0, resp_valid[1]}, 32'd0);
      repeat (3) @(negedge clk);
      chk("flush/no_resp", {31'd0, resp_valid[1]}, 32'd0);
      chk("flush/we_cycles", 32'(we_cnt[1] - w0), 32'd0);
      push(32'h11223344, 5'd4, 1'b1, 1'b0, 32'd0);
      send(1, O_LW, 32'h40, 32'd0, 5'd4, 1'b1);
      get_resp(1, 4, 0, "lw_after_flush");

      // asynchronous reset in the middle of an access
      send(1, O_LW, 32'h40, 32'd0, 5'd5, 1'b1);
      @(posedge clk);
      #1;
      chk("arst/pre_ram_en", {31'd0, ram_en[1]}, 32'd1);
      rst = 1'b0;
      #1;
      chk("arst/ram_en", {31'd0, ram_en[1]}, 32'd0);
      chk("arst/ram_addr", ram_addr[1], 32'd0);
      chk("arst/req_ready", {31'd0, req_ready[1]}, 32'd0);
      chk("arst/resp_valid", {31'd0, resp_valid[1]}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("arst/no_resp", {31'd0, resp_valid[1]}, 32'd0);
      chk("arst/ready", {31'd0, req_ready[1]}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
